// File: rtl/serial_xfer_sequencer_pkg.sv
// Shared types and helpers for the serial transfer sequencer: FSM state
// encoding, default widths and the request-length mapping.
package serial_xfer_sequencer_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int LEN_W_DEF      = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_DONE
  } state_t;

  // A zero or oversized request length means a full-width transfer.
  function automatic int unsigned eff_len(input int unsigned len, input int unsigned width);
    return (len == 0 || len > width) ? width : len;
  endfunction

endpackage

// File: rtl/serial_xfer_sequencer_if.sv
// Upstream request/response port of the serial transfer sequencer.
interface serial_xfer_sequencer_if
  import serial_xfer_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int LEN_W      = LEN_W_DEF
);
  logic                  req_valid;
  logic                  req_ready;
  logic [DATA_WIDTH-1:0] req_data;
  logic [LEN_W-1:0]      req_len;
  logic                  abort;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  busy;

  modport master (
    output req_valid, req_data, req_len, abort,
    input  req_ready, rsp_valid, rsp_data, busy
  );

  modport slave (
    input  req_valid, req_data, req_len, abort,
    output req_ready, rsp_valid, rsp_data, busy
  );
endinterface

// File: rtl/serial_xfer_sequencer_shift_pair.sv
// Transmit/receive shift registers for one MSB-first transfer, with the
// length-indexed transmit bit select and the receive-side length mask.
module serial_shift_pair
  import serial_xfer_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int LEN_W      = LEN_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic [LEN_W-1:0]      load_len,
  input  logic                  shift,
  input  logic                  sample,
  input  logic                  din,
  input  logic [LEN_W-1:0]      len,
  output logic                  tx_bit,
  output logic [DATA_WIDTH-1:0] rx_masked
);

  logic [DATA_WIDTH-1:0] tx_sr, tx_d, rx_sr, tx_view;
  logic [LEN_W-1:0]      len_sel;

  always_comb begin
    // NOTE: default first so every path assigns tx_d and no latch is inferred.
    tx_d = tx_sr;
    if (load)       tx_d = load_data;
    else if (shift) tx_d = tx_sr << 1;
  end

  // tx_bit is the bit ser_dout must carry after this edge's load or shift.
  assign len_sel   = load ? load_len : len;
  assign tx_view   = tx_d >> (len_sel - LEN_W'(1));
  assign tx_bit    = tx_view[0];
  assign rx_masked = rx_sr & ~({DATA_WIDTH{1'b1}} << len);

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
    if (!reset) begin
      tx_sr <= '0;
      rx_sr <= '0;
    end else begin
      tx_sr <= tx_d;
      if (load)        rx_sr <= '0;
      else if (sample) rx_sr <= {rx_sr[DATA_WIDTH-2:0], din};
    end
  end

endmodule

// File: rtl/serial_xfer_sequencer.sv
// Sequences one MSB-first serial transfer on top of an external divided-clock
// generator: chip-select guard time, bit shifting/sampling, response pulse.
module serial_xfer_sequencer
  import serial_xfer_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int LEN_W      = LEN_W_DEF,
  parameter int CS_GUARD   = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  serial_xfer_sequencer_if.slave        req_if,
  output logic                          sclk_enable,
  input  logic                          sclk_level,
  input  logic                          sclk_rise,
  input  logic                          sclk_fall,
  input  logic                          sclk_mid_high,
  input  logic                          sclk_mid_low,
  output logic                          ser_cs_n,
  output logic                          ser_dout,
  input  logic                          ser_din
);

  localparam logic [3:0] GUARD_INIT = 4'(CS_GUARD);

  state_t                state;
  logic [LEN_W-1:0]      len_q, bit_cnt, bit_cnt_inc, len_eff;
  logic [3:0]            guard_cnt;
  logic                  req_ready_q, rsp_valid_q, busy_q;
  logic [DATA_WIDTH-1:0] rsp_data_q, rx_masked;
  logic                  load, shift, sample, tx_bit, last_fall;

  // Level, rise and mid-low strobes are monitor-only and deliberately ignored.
  logic unused_strobes;
  assign unused_strobes = ^{sclk_level, sclk_rise, sclk_mid_low};

  assign len_eff     = LEN_W'(eff_len(32'(req_if.req_len), DATA_WIDTH));
  assign load        = (state == ST_IDLE) && req_ready_q && req_if.req_valid;
  assign sample      = (state == ST_SHIFT) && sclk_mid_high;
  assign shift       = (state == ST_SHIFT) && sclk_fall;
  assign bit_cnt_inc = (bit_cnt == '1) ? bit_cnt : bit_cnt + LEN_W'(1);
  assign last_fall   = (bit_cnt_inc == len_q);

  serial_shift_pair #(.DATA_WIDTH(DATA_WIDTH), .LEN_W(LEN_W)) u_shift_pair (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .load_data (req_if.req_data),
    .load_len  (len_eff),
    .shift     (shift),
    .sample    (sample),
    .din       (ser_din),
    .len       (len_q),
    .tx_bit    (tx_bit),
    .rx_masked (rx_masked)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      len_q       <= '0;
      bit_cnt     <= '0;
      guard_cnt   <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
      sclk_enable <= 1'b0;
      ser_cs_n    <= 1'b1;
      ser_dout    <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      if (req_if.abort && state != ST_IDLE) begin
        state       <= ST_IDLE;
        sclk_enable <= 1'b0;
        ser_cs_n    <= 1'b1;
        ser_dout    <= 1'b0;
        busy_q      <= 1'b0;
        req_ready_q <= 1'b1;
      end else begin
        unique case (state)
          ST_IDLE: begin
            req_ready_q <= 1'b1;
            if (load) begin
              len_q       <= len_eff;
              bit_cnt     <= '0;
              guard_cnt   <= GUARD_INIT;
              ser_cs_n    <= 1'b0;
              ser_dout    <= tx_bit;
              req_ready_q <= 1'b0;
              busy_q      <= 1'b1;
              state       <= ST_SETUP;
            end
          end
          ST_SETUP: begin
            if (guard_cnt == 4'd0) begin
              sclk_enable <= 1'b1;
              state       <= ST_SHIFT;
            end else begin
              guard_cnt <= guard_cnt - 4'd1;
            end
          end
          ST_SHIFT: begin
            if (sclk_fall) begin
              bit_cnt <= bit_cnt_inc;
              if (last_fall) begin
                sclk_enable <= 1'b0;
                guard_cnt   <= GUARD_INIT;
                state       <= ST_HOLD;
              end else begin
                ser_dout <= tx_bit;
              end
            end
          end
          ST_HOLD: begin
            if (guard_cnt == 4'd0) state <= ST_DONE;
            else                   guard_cnt <= guard_cnt - 4'd1;
          end
          ST_DONE: begin
            ser_cs_n    <= 1'b1;
            ser_dout    <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= rx_masked;
            busy_q      <= 1'b0;
            req_ready_q <= 1'b1;
            state       <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign req_if.req_ready = req_ready_q;
  assign req_if.rsp_valid = rsp_valid_q;
  assign req_if.rsp_data  = rsp_data_q;
  assign req_if.busy      = busy_q;

endmodule

// File: tb/tb_serial_xfer_sequencer.sv
// Scoreboard bench for serial_xfer_sequencer with a behavioural divided-clock
// generator and a loopback / tied-high serial data input.
module tb_serial_xfer_sequencer;

  localparam int DW = 8;
  localparam int LW = 4;
  localparam int G  = 2;
  localparam int H  = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  serial_xfer_sequencer_if #(.DATA_WIDTH(DW), .LEN_W(LW)) bus ();

  logic sclk_enable, sclk_level, sclk_rise, sclk_fall, sclk_mid_high, sclk_mid_low;
  logic ser_cs_n, ser_dout, ser_din;

  serial_xfer_sequencer #(.DATA_WIDTH(DW), .LEN_W(LW), .CS_GUARD(G)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_if        (bus),
    .sclk_enable   (sclk_enable),
    .sclk_level    (sclk_level),
    .sclk_rise     (sclk_rise),
    .sclk_fall     (sclk_fall),
    .sclk_mid_high (sclk_mid_high),
    .sclk_mid_low  (sclk_mid_low),
    .ser_cs_n      (ser_cs_n),
    .ser_dout      (ser_dout),
    .ser_din       (ser_din)
  );

  // Divided-clock generator: period 2*H, level restarts low whenever disabled.
  int unsigned ph;
  logic started;
  bit din_one, coincide, held_mode;

  always @(posedge clk or negedge reset) begin
    if (!reset || !sclk_enable) begin
      ph      <= 0;
      started <= 1'b0;
    end else begin
      ph <= (ph + 1) % (2 * H);
      if (ph == H - 1) started <= 1'b1;
    end
  end

  assign sclk_level    = sclk_enable && (ph >= H);
  assign sclk_rise     = sclk_enable && (ph == H);
  assign sclk_fall     = sclk_enable && started && (ph == 0);
  assign sclk_mid_high = coincide ? sclk_fall : (sclk_enable && (ph == H + H / 2));
  assign sclk_mid_low  = sclk_enable && started && (ph == H / 2);
  assign ser_din       = din_one ? 1'b1 : ser_dout;

  typedef struct {
    logic [DW-1:0] rsp;
    logic [DW-1:0] bits;
    int            len;
  } exp_t;

  exp_t sbq[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor / scoreboard, sampling on the falling clk edge.
  int cyc = 0, last_rsp_cyc = 0, acc_cnt = 0;
  int falls = 0, nbits = 0, lat = 0, cur_len = 0, el;
  bit lat_done = 0, pend_off = 0;
  logic [DW-1:0] gv = '0, m8;
  exp_t e;

  always @(negedge clk) begin
    cyc++;
    if (pend_off) begin
      check(sclk_enable == 1'b0, "enable_off_after_last_fall", sclk_enable, 0);
      pend_off = 0;
    end
    if (!ser_cs_n) begin
      if (sclk_mid_high) begin
        gv = {gv[DW-2:0], ser_dout};
        nbits++;
      end
      if (sclk_fall) begin
        falls++;
        if (falls == cur_len) pend_off = 1;
      end
      if (!lat_done) begin
        if (sclk_enable) begin
          check(lat == G + 1, "cs_to_enable_latency", lat, G + 1);
          lat_done = 1;
        end else begin
          lat++;
        end
      end
    end
    if (bus.rsp_valid) begin
      last_rsp_cyc = cyc;
      check(sbq.size() != 0, "rsp_expected", sbq.size(), 1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        check(bus.rsp_data == e.rsp, "rsp_data", bus.rsp_data, e.rsp);
        check(falls == e.len, "fall_count", falls, e.len);
        check(nbits == e.len, "sample_count", nbits, e.len);
        check(gv == e.bits, "dout_sequence", gv, e.bits);
        check({ser_cs_n, ser_dout, bus.busy, bus.req_ready} == 4'b1001, "done_outputs",
              {ser_cs_n, ser_dout, bus.busy, bus.req_ready}, 4'b1001);
      end
    end
    if (bus.req_valid && bus.req_ready) begin
      el = (bus.req_len == 0 || bus.req_len > DW) ? DW : int'(bus.req_len);
      m8 = DW'((1 << el) - 1);
      e.len  = el;
      e.bits = bus.req_data & m8;
      e.rsp  = din_one ? m8 : (bus.req_data & m8);
      sbq.push_back(e);
      cur_len = el;
      if (held_mode) begin
        acc_cnt++;
        if (acc_cnt == 2) check(cyc == last_rsp_cyc, "b2b_gap", cyc - last_rsp_cyc, 0);
      end
    end
    if (ser_cs_n) begin
      gv = '0; nbits = 0; falls = 0; lat = 0; lat_done = 0;
    end
  end

  task automatic run_xfer(input logic [DW-1:0] d, input logic [LW-1:0] l,
                          input bit one, input bit coin, input bit ab);
    int n;
    din_one  = one;
    coincide = coin;
    n = 0;
    while (!bus.req_ready && n < 200) begin step(); n++; end
    check(bus.req_ready === 1'b1, "ready_before_req", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_data  = d;
    bus.req_len   = l;
    bus.abort     = ab;
    step();
    bus.req_valid = 1'b0;
    bus.abort     = 1'b0;
    check(bus.busy === 1'b1 && ser_cs_n === 1'b0, "accept_outputs", {bus.busy, ser_cs_n}, 2'b10);
    n = 0;
    while (!bus.rsp_valid && n < 600) begin step(); n++; end
    check(bus.rsp_valid === 1'b1, "rsp_arrived", bus.rsp_valid, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, r;
    logic [DW-1:0] prev;
    bus.req_valid = 1'b0; bus.req_data = '0; bus.req_len = '0; bus.abort = 1'b0;
    din_one = 0; coincide = 0; held_mode = 0;

    repeat (3) step();
    check({bus.req_ready, bus.rsp_valid, bus.busy, sclk_enable, ser_cs_n, ser_dout} == 6'b000010,
          "reset_outputs", {bus.req_ready, bus.rsp_valid, bus.busy, sclk_enable, ser_cs_n, ser_dout},
          6'b000010);
    check(bus.rsp_data == 0, "reset_rsp_data", bus.rsp_data, 0);
    #2 reset = 1'b1;
    #1 check(bus.req_ready == 1'b0, "ready_before_first_edge", bus.req_ready, 0);
    step();
    check(bus.req_ready == 1'b1, "ready_after_first_edge", bus.req_ready, 1);

    run_xfer(8'hA5, 4'd8, 0, 0, 0);
    run_xfer(8'h05, 4'd3, 1, 0, 0);
    run_xfer(8'hFF, 4'd0, 0, 0, 0);
    run_xfer(8'hFF, 4'd12, 0, 0, 0);

    // Abort one cycle after the fourth falling strobe.
    din_one = 0; coincide = 0;
    prev = bus.rsp_data;
    bus.req_valid = 1'b1; bus.req_data = 8'h5A; bus.req_len = 4'd8;
    step();
    bus.req_valid = 1'b0;
    n = 0;
    while (falls < 4 && n < 600) begin step(); n++; end
    check(falls == 4, "falls_before_abort", falls, 4);
    bus.abort = 1'b1;
    sbq.delete();
    step();
    bus.abort = 1'b0;
    check({ser_cs_n, sclk_enable, bus.req_ready, bus.busy, bus.rsp_valid} == 5'b10100,
          "abort_outputs", {ser_cs_n, sclk_enable, bus.req_ready, bus.busy, bus.rsp_valid}, 5'b10100);
    check(bus.rsp_data == prev, "abort_rsp_data_held", bus.rsp_data, prev);
    repeat (20) step();

    // Asynchronous reset in the middle of SHIFT.
    bus.req_valid = 1'b1; bus.req_data = 8'h96; bus.req_len = 4'd8;
    step();
    bus.req_valid = 1'b0;
    n = 0;
    while (falls < 2 && n < 600) begin step(); n++; end
    #2 reset = 1'b0;
    sbq.delete();
    #1 check({ser_cs_n, sclk_enable, bus.busy, bus.req_ready} == 4'b1000, "async_reset_outputs",
             {ser_cs_n, sclk_enable, bus.busy, bus.req_ready}, 4'b1000);
    check(bus.rsp_data == 0, "async_reset_rsp_data", bus.rsp_data, 0);
    step(); step();
    #2 reset = 1'b1;
    #1 check(bus.req_ready == 1'b0, "ready_low_at_release", bus.req_ready, 0);
    step();
    check(bus.req_ready == 1'b1, "ready_after_release", bus.req_ready, 1);
    run_xfer(8'h3C, 4'd8, 0, 0, 0);

    // req_valid held high across two transfers, coincident mid_high+fall.
    din_one = 0; coincide = 1; held_mode = 1; acc_cnt = 0;
    bus.req_data = 8'hC3; bus.req_len = 4'd6; bus.req_valid = 1'b1;
    n = 0; r = 0;
    while (r < 2 && n < 1500) begin
      step(); n++;
      if (bus.rsp_valid) r++;
    end
    bus.req_valid = 1'b0;
    check(r == 2, "held_valid_responses", r, 2);
    repeat (5) step();
    check(acc_cnt == 2, "held_valid_accepts", acc_cnt, 2);
    held_mode = 0;

    for (int i = 0; i < 12; i++) begin
      run_xfer(DW'($urandom), LW'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end

    repeat (5) step();
    check(sbq.size() == 0, "scoreboard_drained", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
